btn_debounce_multi: RTL and testbench
=====================================

BTN_DEBOUNCE_MULTI -- requirements
Module: btn_debounce_multi

Interface
REQ-001 Parameter CH, default 4: number of independent button channels, range 1..32.
REQ-002 Parameter STABLE, default 4: consecutive synchronized cycles a new level must hold before it is accepted, range 1..2**CNT_W.
REQ-003 Parameter CNT_W, default 8: stability counter width.
REQ-004 Parameter LONG_CYC, default 16: filtered-high cycles before a long-press pulse, range 1..2**LONG_W-1.
REQ-005 Parameter LONG_W, default 16: long-press counter width.
REQ-006 CLK  input  1  system clock; all state changes on its rising edge.
REQ-007 RST  input  1  reset, asynchronous, active-low.
REQ-008 BTN  input  CH  raw asynchronous button levels, 1 = pressed.
REQ-009 BTNQ  output  CH  debounced level per channel.
REQ-010 PRESS  output  CH  one-cycle pulse on each debounced 0->1 transition.
REQ-011 RELEASE  output  CH  one-cycle pulse on each debounced 1->0 transition.
REQ-012 LONG  output  CH  one-cycle long-press pulse; port is always present.

Function
REQ-013 Each BTN bit SHALL pass through a 2-flop synchronizer (s1, s2) before any other use.
REQ-014 Per channel, when s2 == BTNQ the stability counter SHALL clear to 0.
REQ-015 When s2 != BTNQ and counter < STABLE-1, the counter SHALL increment.
REQ-016 When s2 != BTNQ and counter == STABLE-1, BTNQ SHALL take s2 and the counter SHALL clear, all on the same edge.
REQ-017 A clean level change first sampled on edge 1 SHALL appear on BTNQ at edge STABLE+2 (edge 6 at default).
REQ-018 Any reversion of s2 before acceptance SHALL restart the count from 0, so glitches shorter than STABLE cycles never reach BTNQ.
REQ-019 PRESS/RELEASE SHALL be registered and asserted during exactly the cycle in which BTNQ first shows its new value; they are never both high on one channel.
REQ-020 Channels SHALL be fully independent; simultaneous events on different channels SHALL each produce their own pulses in the same cycle.

Reset
REQ-021 While RST = 0: s1, s2, BTNQ, PRESS, RELEASE, LONG and all counters SHALL be 0, regardless of CLK.
REQ-022 Reset assertion during an in-progress count SHALL discard the count; after release, a held button SHALL be re-qualified from scratch, producing a PRESS at edge STABLE+2 after release.

Configuration
REQ-023 With macro BTN_LONG_PRESS_EN defined, a per-channel counter SHALL count cycles with BTNQ = 1, saturating at LONG_CYC.
REQ-024 With BTN_LONG_PRESS_EN defined, LONG SHALL pulse for one cycle when the counter reaches LONG_CYC, once per press, and the counter SHALL clear when BTNQ = 0.
REQ-025 Without BTN_LONG_PRESS_EN, LONG SHALL be constant 0 and no long-press logic SHALL be synthesized.

Structure
REQ-026 Package btn_debounce_pkg SHALL hold the default constants for CH, STABLE, CNT_W, LONG_CYC and LONG_W.
REQ-027 Sub-module btn_debounce_ch SHALL implement one channel (synchronizer, stability counter, edge pulses, optional long counter).
REQ-028 The top SHALL instantiate CH copies of btn_debounce_ch via a generate loop.

Verification (CLK period 10 ns, default parameters)
REQ-029 RST = 0 with BTN = 4'hF toggling -> all outputs remain 0; after RST = 1 with BTN held at 4'hF -> BTNQ = 4'hF and PRESS = 4'hF for one cycle at edge 6.
REQ-030 BTN[0] chatters 1/0 every 5 ns for 20 ns, then holds at 1 for 300 ns -> BTNQ[0] rises 6 edges after the final stable sample, with exactly one PRESS[0] pulse.
REQ-031 BTN[0] 1-cycle and 3-cycle high glitches -> BTNQ[0], PRESS[0] and RELEASE[0] stay 0.
REQ-032 In the same cycle, BTN[2] rises and BTN[3] falls (BTNQ[3] = 1 beforehand) -> PRESS[2] and RELEASE[3] pulse in the same cycle; other channels are unchanged.
REQ-033 RST pulsed low while the BTN[1] count is at 2 -> the count is lost and PRESS[1] arrives 6 edges after RST is released.
REQ-034 With BTN_LONG_PRESS_EN defined, BTN[0] held for 40 cycles -> LONG[0] pulses once, 16 cycles after BTNQ[0] rises, with no repeat; with the macro undefined, LONG stays 0.

Source files
------------

// File: rtl/btn_debounce_pkg.sv
// rtl/btn_debounce_pkg.sv - default configuration constants for the multi-channel button debouncer
package btn_debounce_pkg;

  localparam int DEF_CH       = 4;
  localparam int DEF_STABLE   = 4;
  localparam int DEF_CNT_W    = 8;
  localparam int DEF_LONG_CYC = 16;
  localparam int DEF_LONG_W   = 16;

endpackage

// File: rtl/btn_debounce_ch.sv
// rtl/btn_debounce_ch.sv - one debounce channel: synchronizer, stability counter, edge pulses, optional long-press (BTN_LONG_PRESS_EN)
module btn_debounce_ch
  import btn_debounce_pkg::*;
#(
  parameter int STABLE   = DEF_STABLE,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int LONG_CYC = DEF_LONG_CYC,
  parameter int LONG_W   = DEF_LONG_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic press,
  output logic rel,
  output logic long_pulse
);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;

  // two-flop synchronizer for the raw asynchronous button level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn;
      s2 <= s1;
    end
  end

  // accept a new level only after it has differed from the current one for STABLE samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      press <= 1'b0;
      rel   <= 1'b0;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(STABLE - 1)) begin
        level <= s2;
        cnt   <= '0;
        press <= s2;
        rel   <= ~s2;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

`ifdef BTN_LONG_PRESS_EN
  logic [LONG_W-1:0] long_cnt;

  // count held cycles, saturate at LONG_CYC and pulse once on reaching it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      long_cnt   <= '0;
      long_pulse <= 1'b0;
    end else begin
      long_pulse <= 1'b0;
      if (!level) begin
        long_cnt <= '0;
      end else if (long_cnt != LONG_W'(LONG_CYC)) begin
        long_cnt   <= long_cnt + LONG_W'(1);
        long_pulse <= (long_cnt == LONG_W'(LONG_CYC - 1));
      end
    end
  end
`else
  logic unused_long_cfg;
  assign unused_long_cfg = ^{LONG_CYC, LONG_W};
  assign long_pulse      = 1'b0;
`endif

endmodule

// File: rtl/btn_debounce_multi.sv
// rtl/btn_debounce_multi.sv - CH independent debounced buttons with press/release/long pulses (BTN_LONG_PRESS_EN)
module btn_debounce_multi
  import btn_debounce_pkg::*;
#(
  parameter int CH       = DEF_CH,
  parameter int STABLE   = DEF_STABLE,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int LONG_CYC = DEF_LONG_CYC,
  parameter int LONG_W   = DEF_LONG_W
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [CH-1:0] BTN,
  output logic [CH-1:0] BTNQ,
  output logic [CH-1:0] PRESS,
  output logic [CH-1:0] RELEASE,
  output logic [CH-1:0] LONG
);

  for (genvar i = 0; i < CH; i++) begin : g_ch
    btn_debounce_ch #(
      .STABLE  (STABLE),
      .CNT_W   (CNT_W),
      .LONG_CYC(LONG_CYC),
      .LONG_W  (LONG_W)
    ) u_ch (
      .clk       (CLK),
      .rst_n     (RST),
      .btn       (BTN[i]),
      .level     (BTNQ[i]),
      .press     (PRESS[i]),
      .rel       (RELEASE[i]),
      .long_pulse(LONG[i])
    );
  end

endmodule

// File: tb/tb_btn_debounce_multi.sv
// tb/tb_btn_debounce_multi.sv - scoreboard bench for btn_debounce_multi (optionally built with BTN_LONG_PRESS_EN)
module tb_btn_debounce_multi;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [3:0] BTN = 4'h0;
  logic [3:0] BTNQ;
  logic [3:0] PRESS;
  logic [3:0] RELEASE;
  logic [3:0] LONG;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int         cyc;
    logic [3:0] p;
    logic [3:0] r;
    logic [3:0] l;
  } ev_t;

  ev_t sb[$];

  btn_debounce_multi dut (
    .CLK    (CLK),
    .RST    (RST),
    .BTN    (BTN),
    .BTNQ   (BTNQ),
    .PRESS  (PRESS),
    .RELEASE(RELEASE),
    .LONG   (LONG)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc = cyc + 1;

  // every cycle: pop the events due now and compare all pulse outputs
  always @(negedge CLK) begin
    logic [3:0] ep, er, el;
    int k;
    ep = '0; er = '0; el = '0;
    k = 0;
    while (k < sb.size()) begin
      if (sb[k].cyc == cyc) begin
        ep |= sb[k].p; er |= sb[k].r; el |= sb[k].l;
        sb.delete(k);
      end else begin
        k++;
      end
    end
    total++;
    if (PRESS !== ep) begin
      bad++;
      $display("FAIL press cyc=%0d got=%h exp=%h", cyc, PRESS, ep);
    end
    total++;
    if (RELEASE !== er) begin
      bad++;
      $display("FAIL release cyc=%0d got=%h exp=%h", cyc, RELEASE, er);
    end
    total++;
    if (LONG !== el) begin
      bad++;
      $display("FAIL long cyc=%0d got=%h exp=%h", cyc, LONG, el);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic push(input int at, input logic [3:0] p, input logic [3:0] r, input logic [3:0] l);
    ev_t e;
    e.cyc = at; e.p = p; e.r = r; e.l = l;
    sb.push_back(e);
  endtask

  task automatic check_q(input string name, input logic [3:0] exp);
    total++;
    if (BTNQ !== exp) begin
      bad++;
      $display("FAIL %s btnq got=%h exp=%h", name, BTNQ, exp);
    end
  endtask

  task automatic test_reset();
    RST = 1'b0;
    for (int i = 0; i < 12; i++) begin
      #3 BTN = ~BTN;
      total++;
      if ({BTNQ, PRESS, RELEASE, LONG} !== 16'h0) begin
        bad++;
        $display("FAIL reset_hold outs got=%h exp=0", {BTNQ, PRESS, RELEASE, LONG});
      end
    end
    step(1);
    BTN = 4'hF;
    step(2);
    RST = 1'b1;
    push(cyc + 6, 4'hF, 4'h0, 4'h0);
    step(5);
    check_q("reset_pre", 4'h0);
    step(1);
    check_q("reset_rise", 4'hF);
    BTN = 4'h0;
    push(cyc + 6, 4'h0, 4'hF, 4'h0);
    step(8);
    check_q("reset_fall", 4'h0);
  endtask

  task automatic test_chatter();
    BTN[0] = 1'b1; #5;
    BTN[0] = 1'b0; #5;
    BTN[0] = 1'b1; #5;
    BTN[0] = 1'b0; #5;
    BTN[0] = 1'b1;
    push(cyc + 6, 4'h1, 4'h0, 4'h0);
    step(5);
    check_q("chatter_pre", 4'h0);
    step(25);
    check_q("chatter_held", 4'h1);
    BTN[0] = 1'b0;
    push(cyc + 6, 4'h0, 4'h1, 4'h0);
    step(8);
    check_q("chatter_fall", 4'h0);
  endtask

  task automatic test_glitch();
    BTN[0] = 1'b1;
    step(1);
    BTN[0] = 1'b0;
    step(8);
    check_q("glitch1", 4'h0);
    BTN[0] = 1'b1;
    step(3);
    BTN[0] = 1'b0;
    step(8);
    check_q("glitch3", 4'h0);
  endtask

  task automatic test_simultaneous();
    BTN[3] = 1'b1;
    push(cyc + 6, 4'h8, 4'h0, 4'h0);
    step(8);
    check_q("simul_pre", 4'h8);
    BTN[2] = 1'b1;
    BTN[3] = 1'b0;
    push(cyc + 6, 4'h4, 4'h8, 4'h0);
    step(8);
    check_q("simul_post", 4'h4);
    BTN[2] = 1'b0;
    push(cyc + 6, 4'h0, 4'h4, 4'h0);
    step(8);
    check_q("simul_clear", 4'h0);
  endtask

  task automatic test_reset_midcount();
    BTN[1] = 1'b1;
    step(4);
    RST = 1'b0;
    #2;
    check_q("midrst_asserted", 4'h0);
    step(3);
    RST = 1'b1;
    push(cyc + 6, 4'h2, 4'h0, 4'h0);
    step(5);
    check_q("midrst_pre", 4'h0);
    step(1);
    check_q("midrst_rise", 4'h2);
    BTN[1] = 1'b0;
    push(cyc + 6, 4'h0, 4'h2, 4'h0);
    step(8);
  endtask

  task automatic test_long();
    int rise;
    BTN[0] = 1'b1;
    rise = cyc + 6;
    push(rise, 4'h1, 4'h0, 4'h0);
`ifdef BTN_LONG_PRESS_EN
    push(rise + 16, 4'h0, 4'h0, 4'h1);
`endif
    step(40);
    check_q("long_held", 4'h1);
    BTN[0] = 1'b0;
    push(cyc + 6, 4'h0, 4'h1, 4'h0);
    step(10);
    check_q("long_fall", 4'h0);
    BTN[0] = 1'b1;
    push(cyc + 6, 4'h1, 4'h0, 4'h0);
    step(12);
    BTN[0] = 1'b0;
    push(cyc + 6, 4'h0, 4'h1, 4'h0);
    step(10);
  endtask

  initial begin
    test_reset();
    test_chatter();
    test_glitch();
    test_simultaneous();
    test_reset_midcount();
    test_long();
    step(4);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
